// File: rtl/rng_buffer.sv
// Random-word FIFO fed by full generator words or four packed nibbles; head is fall-through, valid the edge after a push.
// No upstream backpressure: a push into a full FIFO without a same-cycle pop is dropped and counted.
module rng_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic [WIDTH-1:0]           rng_in,
  input  logic [3:0]                 rng_nibble,
  input  logic                       sample_en,
  input  logic                       pack_mode,
  input  logic                       clear,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic [1:0]       idx, idx_eff, idx_nxt;
  logic [11:0]      part, part_eff, part_nxt;
  logic             mode_q, mode_chg;
  logic             push_req, push_ok, pop, drop;
  logic [WIDTH-1:0] push_dat;

  assign count      = cnt;
  assign empty      = (cnt == '0);
  assign full       = (cnt == CW'(DEPTH));
  assign dout_valid = !empty;
  assign dout       = mem[rd_ptr];

  // A mode flip abandons any partial word; this cycle's sample restarts at idx 0.
  always_comb begin
    mode_chg = (pack_mode != mode_q);
    idx_eff  = mode_chg ? 2'd0 : idx;
    part_eff = mode_chg ? 12'd0 : part;
    idx_nxt  = idx_eff;
    part_nxt = part_eff;
    push_req = 1'b0;
    push_dat = rng_in;
    if (sample_en) begin
      if (!pack_mode) begin
        push_req = 1'b1;
      end else if (idx_eff == 2'd3) begin
        push_req = 1'b1;
        push_dat = WIDTH'({rng_nibble, part_eff});
        idx_nxt  = 2'd0;
        part_nxt = 12'd0;
      end else begin
        idx_nxt  = idx_eff + 2'd1;
        part_nxt = part_eff | (12'(rng_nibble) << {idx_eff, 2'b00});
      end
    end
    pop     = !empty && dout_ready;
    push_ok = push_req && (!full || pop);
    drop    = push_req && !push_ok;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      idx        <= 2'd0;
      part       <= 12'd0;
      mode_q     <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      idx        <= 2'd0;
      part       <= 12'd0;
      mode_q     <= pack_mode;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      mode_q <= pack_mode;
      idx    <= idx_nxt;
      part   <= part_nxt;
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_ok && !pop)      cnt <= cnt + CW'(1);
      else if (!push_ok && pop) cnt <= cnt - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Storage is not reset; when full with a pop, the tail slot is the head being read out.
  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: doc/rng_buffer.md
RNG_BUFFER -- requirements
Module: rng_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter: WIDTH, 16, word width, equal to the generator output width.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: nreset  input  1  asynchronous, active-low reset.
REQ-005 Port: rng_in  input  WIDTH  full random word from the upstream random generator.
REQ-006 Port: rng_nibble  input  4  4-bit random value from the upstream generator.
REQ-007 Port: sample_en  input  1  when 1, one sample is taken on this edge.
REQ-008 Port: pack_mode  input  1  0 = word mode (push rng_in); 1 = pack mode (pack 4 nibbles per word).
REQ-009 Port: clear  input  1  synchronous flush of all state.
REQ-010 Port: dout  output  WIDTH  word at the FIFO head.
REQ-011 Port: dout_valid  output  1  head word is valid.
REQ-012 Port: dout_ready  input  1  consumer accepts the head word.
REQ-013 Port: count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-014 Port: full  output  1  count == DEPTH.
REQ-015 Port: empty  output  1  count == 0.
REQ-016 Port: overflow  output  1  sticky flag: at least one word was dropped.
REQ-017 Port: drop_count  output  8  dropped words, saturating at 255.

Function
REQ-018 Word mode: a cycle with sample_en=1 generates a push request carrying rng_in.
REQ-019 Pack mode: a sample with sample_en=1 writes rng_nibble into word bits [4*idx+3:4*idx], idx = 0..3, first nibble in bits [3:0].
REQ-020 Pack mode: the sample with idx=3 generates a push request carrying the completed word (current nibble included), and idx wraps to 0.
REQ-021 A pack_mode change while idx!=0 discards the partial word and sets idx=0, with no push; the sample in that cycle is processed in the new mode from idx=0.
REQ-022 Pop occurs on a rising edge where dout_valid=1 and dout_ready=1; the read pointer advances modulo DEPTH.
REQ-023 A push request is accepted if full=0, or if full=1 and a pop occurs in the same cycle; the write pointer advances modulo DEPTH.
REQ-024 Simultaneous accepted push and pop leaves count unchanged.
REQ-025 A push request that is not accepted drops the word, sets overflow=1 and increments drop_count, saturating at 255; FIFO contents are unchanged.
REQ-026 dout = storage[rd_ptr] (first-word fall-through); dout_valid = !empty; dout is don't-care when empty.
REQ-027 Latency: a word pushed at edge N is visible on dout with dout_valid=1 after edge N when the FIFO was empty.
REQ-028 A pop when empty cannot occur, because dout_valid=0.
REQ-029 count, full, empty, overflow and drop_count are registered or derived from registered state only, with no combinational path from any input.
REQ-030 clear=1 takes priority over push and pop: pointers, count and idx go to 0, the partial word goes to 0, overflow goes to 0 and drop_count goes to 0; the sample in that cycle is discarded.

Reset
REQ-031 nreset=0 asynchronously forces pointers=0, count=0, idx=0, partial word=0, overflow=0 and drop_count=0; hence empty=1, full=0 and dout_valid=0.
REQ-032 Storage contents are not reset.
REQ-033 Reset asserted mid-operation discards all buffered and partial data; the first sample after release restarts at idx=0.
REQ-034 The release of nreset is not synchronised internally; the integrating top level provides release away from the clock edge (for example, a 20-unit clock period with release at t=25).

Verification
REQ-035 Word mode: rng_in=16'hA5A5 with sample_en=1 for 1 cycle -> next cycle dout=16'hA5A5, dout_valid=1, count=1; dout_ready=1 -> empty=1.
REQ-036 Pack mode: nibbles 1,2,3,4 on consecutive samples -> after the 4th sample dout=16'h4321 and count=1; after the 3rd sample count=0.
REQ-037 Fill and overflow: dout_ready=0 with 10 word-mode samples -> count=8, full=1, overflow=1, drop_count=2; dout shows the first sample.
REQ-038 Full with simultaneous push and pop: full=1, dout_ready=1 and sample_en=1 -> count stays 8, drop_count unchanged, new word stored at the tail.
REQ-039 Saturation and clear: 300 dropped words -> drop_count=255; then clear=1 for 1 cycle -> count=0, overflow=0, drop_count=0.
REQ-040 Reset and mode switch: pack 2 nibbles and then toggle pack_mode -> no push occurs; pack 2 nibbles and then assert nreset=0 mid-cycle -> empty=1 immediately; after release, 4 nibbles 5,6,7,8 -> dout=16'h8765.
